fetch_bundle_queue: RTL and testbench

Parametrised elastic buffer between fetch stages, carrying fetch bundles (LANES lanes of packed packet/predictor payload) from Fetch-1 to Fetch-2. It replaces the global-stall pipeline register with a valid/ready handshake and a DEPTH-entry FIFO, so back-pressure from Fetch-2 no longer has to reach Fetch-1 in the same cycle. It also adds per-lane valid tracking, zero-lane bundle dropping, and an occupancy output.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_bundle_queue_ctrl.sv | 58 +++++
 rtl/fetch_bundle_queue.sv | 101 ++++++++++
 tb/tb_fetch_bundle_queue.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and default sizing for the Fetch-1 to Fetch-2 bundle queue.
package fetch_pkg;

    localparam int unsigned FETCH_LANES_DEFAULT   = 4;
    localparam int unsigned FETCH_PKT_W_DEFAULT   = 64;
    localparam int unsigned FETCH_Q_DEPTH_DEFAULT = 2;

    // Lane payload is the caller's concatenation of packet, predCounter and predIndex.
    typedef logic [FETCH_PKT_W_DEFAULT-1:0] fetch_lane_t;

    typedef struct packed {
        logic [FETCH_LANES_DEFAULT-1:0]  mask;
        fetch_lane_t [FETCH_LANES_DEFAULT-1:0] lanes;
    } fetch_bundle_t;

endpackage

// File: rtl/fetch_bundle_queue_ctrl.sv
// Pointer, count and handshake qualification for fetch_bundle_queue.
// Flush and reset both clear state and suppress any push or pop in the same cycle.
module fetch_bundle_queue_ctrl #(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push_req,
    input  logic             pop_req,
    output logic             push_en,
    output logic             pop_en,
    output logic             in_ready,
    output logic             valid,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [OCC_W-1:0] count
);

    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] count_q;

    // Ready depends only on registered count, never on pop_req.
    assign in_ready = (count_q != DEPTH_OCC);
    assign valid    = (count_q != '0);
    assign push_en  = push_req & in_ready & ~flush;
    assign pop_en   = pop_req & valid & ~flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_en && !pop_en) begin
                count_q <= count_q + 1'b1;
            end else if (pop_en && !push_en) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

endmodule

// File: rtl/fetch_bundle_queue.sv
// Elastic valid/ready FIFO carrying fetch bundles from Fetch-1 to Fetch-2, dropping zero-lane bundles.
// Optional lane power gating is enabled by defining FETCH_LANE_GATE_EN.
module fetch_bundle_queue
    import fetch_pkg::*;
#(
    parameter int unsigned LANES = FETCH_LANES_DEFAULT,
    parameter int unsigned PKT_W = FETCH_PKT_W_DEFAULT,
    parameter int unsigned DEPTH = FETCH_Q_DEPTH_DEFAULT,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
`ifdef FETCH_LANE_GATE_EN
    input  logic [LANES-1:0]       laneActive_i,
`endif
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [LANES-1:0]       in_lane_valid_i,
    input  logic [LANES*PKT_W-1:0] in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [LANES-1:0]       out_lane_valid_o,
    output logic [LANES*PKT_W-1:0] out_data_o,
    output logic [OCC_W-1:0]       occupancy_o
);

    logic [LANES-1:0] em;
    logic [LANES-1:0] lane_we;
    logic             push_en;
    logic             pop_en;
    logic             head_valid;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LANES-1:0] stored_mask;

    // Entry storage is deliberately not reset; empty-state outputs are forced to zero instead.
    logic [LANES-1:0] mask_mem [DEPTH];
    logic [PKT_W-1:0] data_mem [DEPTH][LANES];

`ifdef FETCH_LANE_GATE_EN
    assign em      = in_lane_valid_i & laneActive_i;
    assign lane_we = em;
`else
    assign em      = in_lane_valid_i;
    assign lane_we = '1;
`endif

    fetch_bundle_queue_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush_i),
        .push_req (in_valid_i & (em != '0)),
        .pop_req  (out_ready_i),
        .push_en  (push_en),
        .pop_en   (pop_en),
        .in_ready (in_ready_o),
        .valid    (head_valid),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (occupancy_o)
    );

    always_ff @(posedge clk) begin
        if (push_en) begin
            mask_mem[wr_ptr] <= em;
            for (int l = 0; l < LANES; l++) begin
                if (lane_we[l]) begin
                    data_mem[wr_ptr][l] <= in_data_i[l*PKT_W +: PKT_W];
                end
            end
        end
    end

    always_comb begin
        stored_mask = '0;
        out_data_o  = '0;
        if (head_valid) begin
            stored_mask = mask_mem[rd_ptr];
            for (int l = 0; l < LANES; l++) begin
                out_data_o[l*PKT_W +: PKT_W] = data_mem[rd_ptr][l];
            end
        end
    end

    assign out_valid_o = head_valid;

`ifdef FETCH_LANE_GATE_EN
    assign out_lane_valid_o = stored_mask & laneActive_i;
`else
    assign out_lane_valid_o = stored_mask;
`endif

    // pop_en only feeds the controller's pointer update.
    logic unused_pop_en;
    assign unused_pop_en = pop_en;

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Directed self-checking bench for fetch_bundle_queue (LANES=4, PKT_W=64, DEPTH=2).
module tb_fetch_bundle_queue;

    localparam int unsigned LANES = 4;
    localparam int unsigned PKT_W = 64;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned DW    = LANES * PKT_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [3:0]    in_lane_valid_i;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [3:0]    out_lane_valid_o;
    logic [DW-1:0] out_data_o;
    logic [1:0]    occupancy_o;
`ifdef FETCH_LANE_GATE_EN
    logic [3:0]    lane_active;
`endif

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    fetch_bundle_queue #(
        .LANES (LANES),
        .PKT_W (PKT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .flush_i          (flush_i),
`ifdef FETCH_LANE_GATE_EN
        .laneActive_i     (lane_active),
`endif
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_lane_valid_i  (in_lane_valid_i),
        .in_data_i        (in_data_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_lane_valid_o (out_lane_valid_o),
        .out_data_o       (out_data_o),
        .occupancy_o      (occupancy_o)
    );

    function automatic logic [DW-1:0] mk(input logic [7:0] tag);
        logic [DW-1:0] r;
        for (int l = 0; l < LANES; l++) begin
            r[l*PKT_W +: PKT_W] = {tag, 8'(l), 48'h5A5A_C3C3_0F0F};
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i         = 1'b0;
        in_valid_i      = 1'b0;
        in_lane_valid_i = 4'b0000;
        in_data_i       = '0;
        out_ready_i     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total_cnt++;
        if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (out_lane_valid_o !== 4'b0000)
            $display("FAIL reset_lane_valid: got %b want 0000", out_lane_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (out_data_o !== '0) $display("FAIL reset_data: got %h want 0", out_data_o);
        else pass_cnt++;
        total_cnt++;
        if (occupancy_o !== 2'd0) $display("FAIL reset_occ: got %0d want 0", occupancy_o);
        else pass_cnt++;
        total_cnt++;
        if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready_o);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        in_valid_i      = 1'b1;
        in_lane_valid_i = 4'b1111;
        in_data_i       = mk(8'hA1);
        step();
        in_data_i = mk(8'hB2);
        total_cnt++;
        if (out_valid_o !== 1'b1) $display("FAIL fill1_valid: got %b want 1", out_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (out_data_o !== mk(8'hA1)) $display("FAIL fill1_data: got %h want %h", out_data_o, mk(8'hA1));
        else pass_cnt++;
        total_cnt++;
        if (out_lane_valid_o !== 4'b1111)
            $display("FAIL fill1_lane_valid: got %b want 1111", out_lane_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (occupancy_o !== 2'd1) $display("FAIL fill1_occ: got %0d want 1", occupancy_o);
        else pass_cnt++;
        step();
        total_cnt++;
        if (occupancy_o !== 2'd2) $display("FAIL fill2_occ: got %0d want 2", occupancy_o);
        else pass_cnt++;
        total_cnt++;
        if (in_ready_o !== 1'b0) $display("FAIL fill2_in_ready: got %b want 0", in_ready_o);
        else pass_cnt++;
        total_cnt++;
        if (out_data_o !== mk(8'hA1)) $display("FAIL fill2_head_stable: got %h want %h", out_data_o, mk(8'hA1));
        else pass_cnt++;
    endtask

    task automatic test_full_pop();
        // Full: the pop happens, the offered bundle is refused.
        in_valid_i  = 1'b1;
        in_data_i   = mk(8'hC3);
        out_ready_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        total_cnt++;
        if (occupancy_o !== 2'd1) $display("FAIL fullpop_occ: got %0d want 1", occupancy_o);
        else pass_cnt++;
        total_cnt++;
        if (out_data_o !== mk(8'hB2)) $display("FAIL fullpop_head: got %h want %h", out_data_o, mk(8'hB2));
        else pass_cnt++;
        step();
        total_cnt++;
        if (occupancy_o !== 2'd0) $display("FAIL fullpop_drain_occ: got %0d want 0 (C3 refused)", occupancy_o);
        else pass_cnt++;
        total_cnt++;
        if (out_valid_o !== 1'b0) $display("FAIL fullpop_drain_valid: got %b want 0", out_valid_o);
        else pass_cnt++;
        out_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready_i     = 1'b1;
        in_lane_valid_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = mk(8'(8'h10 + i));
            step();
            total_cnt++;
            if (out_valid_o !== 1'b1 || out_data_o !== mk(8'(8'h10 + i)))
                $display("FAIL b2b_out[%0d]: got v=%b %h want v=1 %h", i, out_valid_o, out_data_o,
                         mk(8'(8'h10 + i)));
            else pass_cnt++;
            total_cnt++;
            if (occupancy_o !== 2'd1) $display("FAIL b2b_occ[%0d]: got %0d want 1", i, occupancy_o);
            else pass_cnt++;
        end
        in_valid_i = 1'b0;
        step();
        total_cnt++;
        if (occupancy_o !== 2'd0) $display("FAIL b2b_drain_occ: got %0d want 0", occupancy_o);
        else pass_cnt++;
        out_ready_i = 1'b0;
    endtask

    task automatic test_zero_mask();
        in_valid_i      = 1'b1;
        in_lane_valid_i = 4'b0000;
        in_data_i       = mk(8'hEE);
        #1;
        total_cnt++;
        if (in_ready_o !== 1'b1) $display("FAIL zero_in_ready: got %b want 1", in_ready_o);
        else pass_cnt++;
        step();
        in_valid_i = 1'b0;
        total_cnt++;
        if (occupancy_o !== 2'd0) $display("FAIL zero_occ: got %0d want 0", occupancy_o);
        else pass_cnt++;
        total_cnt++;
        if (out_valid_o !== 1'b0) $display("FAIL zero_valid: got %b want 0", out_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        in_valid_i      = 1'b1;
        in_lane_valid_i = 4'b1111;
        in_data_i       = mk(8'h21);
        step();
        in_data_i = mk(8'h22);
        step();
        total_cnt++;
        if (occupancy_o !== 2'd2) $display("FAIL flush_pre_occ: got %0d want 2", occupancy_o);
        else pass_cnt++;
        flush_i   = 1'b1;
        in_data_i = mk(8'h23);
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        total_cnt++;
        if (occupancy_o !== 2'd0) $display("FAIL flush_occ: got %0d want 0", occupancy_o);
        else pass_cnt++;
        total_cnt++;
        if (out_valid_o !== 1'b0) $display("FAIL flush_valid: got %b want 0", out_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (out_data_o !== '0) $display("FAIL flush_data: got %h want 0", out_data_o);
        else pass_cnt++;
        total_cnt++;
        if (in_ready_o !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", in_ready_o);
        else pass_cnt++;
        // One held entry, so in_ready is high while flush and push coincide.
        in_valid_i = 1'b1;
        in_data_i  = mk(8'h24);
        step();
        flush_i   = 1'b1;
        in_data_i = mk(8'h25);
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        step();
        total_cnt++;
        if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0)
            $display("FAIL flush_push_lost: got occ=%0d v=%b want occ=0 v=0", occupancy_o, out_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        in_valid_i      = 1'b1;
        in_lane_valid_i = 4'b1111;
        in_data_i       = mk(8'h31);
        step();
        in_valid_i = 1'b0;
        reset      = 1'b1;
        step();
        reset = 1'b0;
        total_cnt++;
        if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0 || out_data_o !== '0)
            $display("FAIL reset_mid: got occ=%0d v=%b d=%h want 0/0/0", occupancy_o, out_valid_o, out_data_o);
        else pass_cnt++;
    endtask

`ifdef FETCH_LANE_GATE_EN
    task automatic test_lane_gate();
        lane_active     = 4'b0011;
        in_valid_i      = 1'b1;
        in_lane_valid_i = 4'b1111;
        in_data_i       = mk(8'h41);
        step();
        in_valid_i = 1'b0;
        total_cnt++;
        if (out_lane_valid_o !== 4'b0011) $display("FAIL gate_mask: got %b want 0011", out_lane_valid_o);
        else pass_cnt++;
        lane_active = 4'b0001;
        #1;
        total_cnt++;
        if (out_lane_valid_o !== 4'b0001) $display("FAIL gate_powerdown: got %b want 0001", out_lane_valid_o);
        else pass_cnt++;
        out_ready_i     = 1'b1;
        lane_active     = 4'b0011;
        in_valid_i      = 1'b1;
        in_lane_valid_i = 4'b1100;
        step();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        total_cnt++;
        if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0)
            $display("FAIL gate_drop: got occ=%0d v=%b want 0/0", occupancy_o, out_valid_o);
        else pass_cnt++;
        lane_active = 4'b1111;
    endtask
`endif

    initial begin
`ifdef FETCH_LANE_GATE_EN
        lane_active = 4'b1111;
`endif
        test_reset();
        test_fill();
        test_full_pop();
        test_back_to_back();
        test_zero_mask();
        test_flush();
        test_reset_mid();
`ifdef FETCH_LANE_GATE_EN
        test_lane_gate();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
